jump_ctrl: RTL and testbench

- Drives the program counter's jump_en/target inputs: the redirect source that the PC consumes.
- Decodes control-flow ops from the fetch/decode stage into a redirect request: JMP, BZ, BNZ, CALL, RET.
- Holds a writable branch-target lookup table (LUT) so narrow instructions address full D-bit targets through a 4-bit index.
- Holds a return-address stack for CALL/RET.
- Redirect outputs are combinational from current inputs and registered state, so the PC redirects on the next clk edge.

---
 rtl/jump_pkg.sv | 18 +
 rtl/ret_stack.sv | 58 +++++
 rtl/jump_ctrl.sv | 129 ++++++++++++
 tb/tb_jump_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/jump_pkg.sv
// Shared types and default sizes for the jump controller and its return stack.
package jump_pkg;

  localparam int D_DEF         = 6;
  localparam int LUT_IDX_DEF   = 4;
  localparam int STK_DEPTH_DEF = 4;

  // Encodings 6 and 7 are not named; they fall through to the NOP path.
  typedef enum logic [2:0] {
    BR_NOP  = 3'd0,
    BR_JMP  = 3'd1,
    BR_BZ   = 3'd2,
    BR_BNZ  = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5
  } br_op_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. Depth saturates at STK_DEPTH and stops at 0; callers see
// full/empty and are expected to gate push/pop, but the stack also guards itself.
module ret_stack
  import jump_pkg::*;
#(
  parameter int D         = D_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [D-1:0]                 push_data,
  output logic [D-1:0]                 top,
  output logic [$clog2(STK_DEPTH):0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(STK_DEPTH);
  localparam int DW = AW + 1;

  logic [D-1:0]  mem_q [STK_DEPTH];
  logic [D-1:0]  mem_d [STK_DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic [AW-1:0] top_idx, wr_idx;

  assign full    = (depth_q == DW'(STK_DEPTH));
  assign empty   = (depth_q == '0);
  assign top_idx = AW'(depth_q - DW'(1));
  assign wr_idx  = AW'(depth_q);
  assign top     = empty ? '0 : mem_q[top_idx];
  assign depth   = depth_q;

  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (push && !full) begin
      mem_d[wr_idx] = push_data;
      depth_d       = depth_q + DW'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      depth_q <= '0;
      for (int i = 0; i < STK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/jump_ctrl.sv
// Control-flow redirect unit: decodes JMP/BZ/BNZ/CALL/RET into a combinational
// jump_en/target for the PC, with a writable target LUT and a return stack.
module jump_ctrl
  import jump_pkg::*;
#(
  parameter int D         = D_DEF,
  parameter int LUT_IDX   = LUT_IDX_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [D-1:0]                prog_ctr,
  input  logic                        br_valid,
  input  logic [2:0]                  br_op,
  input  logic [LUT_IDX-1:0]          lut_idx,
  input  logic                        zero_flag,
  input  logic                        lut_we,
  input  logic [LUT_IDX-1:0]          lut_waddr,
  input  logic [D-1:0]                lut_wdata,
  output logic                        jump_en,
  output logic [D-1:0]                target,
  output logic [$clog2(STK_DEPTH):0]  stk_depth,
  output logic                        stk_ovf,
  output logic                        stk_udf
);

  localparam int LUT_N = 2 ** LUT_IDX;

  logic [D-1:0] lut_q [LUT_N];
  logic [D-1:0] lut_d [LUT_N];
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;

  logic         push, pop;
  logic         stk_full, stk_empty;
  logic [D-1:0] stk_top;
  logic [D-1:0] ret_addr;
  logic [D-1:0] lut_rd;
  br_op_t       op;

  assign op       = br_op_t'(br_op);
  assign ret_addr = prog_ctr + D'(1);
  assign lut_rd   = lut_q[lut_idx];

  ret_stack #(
    .D         (D),
    .STK_DEPTH (STK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (ret_addr),
    .top       (stk_top),
    .depth     (stk_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Reads see registered LUT contents, so a same-cycle write stays invisible
  // until the next cycle. Decode is masked while reset is held low.
  always_comb begin
    jump_en = 1'b0;
    target  = '0;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    lut_d   = lut_q;
    if (lut_we) begin
      lut_d[lut_waddr] = lut_wdata;
    end
    if (reset && br_valid) begin
      case (op)
        BR_JMP: begin
          jump_en = 1'b1;
          target  = lut_rd;
        end
        BR_BZ: begin
          jump_en = zero_flag;
          target  = zero_flag ? lut_rd : '0;
        end
        BR_BNZ: begin
          jump_en = !zero_flag;
          target  = zero_flag ? '0 : lut_rd;
        end
        BR_CALL: begin
          if (stk_full) begin
            ovf_d = 1'b1;
          end else begin
            jump_en = 1'b1;
            target  = lut_rd;
            push    = 1'b1;
          end
        end
        BR_RET: begin
          if (stk_empty) begin
            udf_d = 1'b1;
          end else begin
            jump_en = 1'b1;
            target  = stk_top;
            pop     = 1'b1;
          end
        end
        default: begin
          jump_en = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
      for (int i = 0; i < LUT_N; i++) begin
        lut_q[i] <= '0;
      end
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
      lut_q <= lut_d;
    end
  end

  assign stk_ovf = ovf_q;
  assign stk_udf = udf_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Scoreboard bench for jump_ctrl: each directed vector queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_jump_ctrl;

  localparam int D       = 6;
  localparam int LUT_IDX = 4;
  localparam int STK     = 4;

  logic               clk;
  logic               reset;
  logic [D-1:0]       prog_ctr;
  logic               br_valid;
  logic [2:0]         br_op;
  logic [LUT_IDX-1:0] lut_idx;
  logic               zero_flag;
  logic               lut_we;
  logic [LUT_IDX-1:0] lut_waddr;
  logic [D-1:0]       lut_wdata;
  logic               jump_en;
  logic [D-1:0]       target;
  logic [2:0]         stk_depth;
  logic               stk_ovf;
  logic               stk_udf;

  typedef struct {
    string        name;
    logic         jen;
    logic [D-1:0] tgt;
    logic [2:0]   depth;
    logic         ovf;
    logic         udf;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, BZ = 3'd2, BNZ = 3'd3,
                         CALL = 3'd4, RET = 3'd5;

  jump_ctrl #(.D(D), .LUT_IDX(LUT_IDX), .STK_DEPTH(STK)) dut (
    .clk       (clk),
    .reset     (reset),
    .prog_ctr  (prog_ctr),
    .br_valid  (br_valid),
    .br_op     (br_op),
    .lut_idx   (lut_idx),
    .zero_flag (zero_flag),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .jump_en   (jump_en),
    .target    (target),
    .stk_depth (stk_depth),
    .stk_ovf   (stk_ovf),
    .stk_udf   (stk_udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_field(input string name, input string field,
                             input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0d expected=%0d", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a queued
  // expectation is compared mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check_field(e.name, "jump_en",   int'(jump_en),   int'(e.jen));
      check_field(e.name, "target",    int'(target),    int'(e.tgt));
      check_field(e.name, "stk_depth", int'(stk_depth), int'(e.depth));
      check_field(e.name, "stk_ovf",   int'(stk_ovf),   int'(e.ovf));
      check_field(e.name, "stk_udf",   int'(stk_udf),   int'(e.udf));
    end
  end

  // Drive one cycle of inputs just after the rising edge; reset is applied
  // two time units later so a low value lands mid-cycle.
  task automatic apply_stimulus(
    input string name, input logic rst, input logic v, input logic [2:0] op,
    input int idx, input logic zf, input int pc,
    input logic we, input int waddr, input int wdata,
    input logic e_jen, input int e_tgt, input int e_depth,
    input logic e_ovf, input logic e_udf);
    exp_t e;
    br_valid  = v;
    br_op     = op;
    lut_idx   = LUT_IDX'(idx);
    zero_flag = zf;
    prog_ctr  = D'(pc);
    lut_we    = we;
    lut_waddr = LUT_IDX'(waddr);
    lut_wdata = D'(wdata);
    e.name  = name;
    e.jen   = e_jen;
    e.tgt   = D'(e_tgt);
    e.depth = 3'(e_depth);
    e.ovf   = e_ovf;
    e.udf   = e_udf;
    sb_q.push_back(e);
    #2;
    reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic op_vec(input string name, input logic [2:0] op, input int idx,
                        input logic zf, input int pc, input logic e_jen,
                        input int e_tgt, input int e_depth,
                        input logic e_ovf, input logic e_udf);
    apply_stimulus(name, 1'b1, 1'b1, op, idx, zf, pc, 1'b0, 0, 0,
                   e_jen, e_tgt, e_depth, e_ovf, e_udf);
  endtask

  task automatic lut_write(input string name, input int waddr, input int wdata,
                           input int e_depth, input logic e_ovf, input logic e_udf);
    apply_stimulus(name, 1'b1, 1'b0, NOP, 0, 1'b0, 0, 1'b1, waddr, wdata,
                   1'b0, 0, e_depth, e_ovf, e_udf);
  endtask

  initial begin
    reset = 1'b0; prog_ctr = '0; br_valid = 1'b0; br_op = '0; lut_idx = '0;
    zero_flag = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
    repeat (2) @(posedge clk);
    #1;

    apply_stimulus("rst_hold", 1'b0, 1'b1, JMP, 0, 1'b0, 0, 1'b0, 0, 0,
                   1'b0, 0, 0, 1'b0, 1'b0);
    apply_stimulus("idle", 1'b1, 1'b0, NOP, 0, 1'b0, 0, 1'b0, 0, 0,
                   1'b0, 0, 0, 1'b0, 1'b0);

    lut_write("wr_lut3", 3, 5, 0, 1'b0, 1'b0);
    op_vec("jmp3",     JMP, 3, 1'b0, 0, 1'b1, 5, 0, 1'b0, 1'b0);
    lut_write("wr_lut2", 2, 40, 0, 1'b0, 1'b0);
    op_vec("bz_taken", BZ,  2, 1'b1, 0, 1'b1, 40, 0, 1'b0, 1'b0);
    op_vec("bz_not",   BZ,  2, 1'b0, 0, 1'b0, 0,  0, 1'b0, 1'b0);
    op_vec("bnz_taken",BNZ, 2, 1'b0, 0, 1'b1, 40, 0, 1'b0, 1'b0);
    op_vec("bnz_not",  BNZ, 2, 1'b1, 0, 1'b0, 0,  0, 1'b0, 1'b0);
    op_vec("op6_nop",  3'd6, 2, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    op_vec("op7_nop",  3'd7, 2, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);

    lut_write("wr_lut1", 1, 20, 0, 1'b0, 1'b0);
    op_vec("call10",  CALL, 1, 1'b0, 10, 1'b1, 20, 0, 1'b0, 1'b0);
    op_vec("ret25",   RET,  0, 1'b0, 25, 1'b1, 11, 1, 1'b0, 1'b0);

    op_vec("ncall10", CALL, 1, 1'b0, 10, 1'b1, 20, 0, 1'b0, 1'b0);
    op_vec("ncall20", CALL, 1, 1'b0, 20, 1'b1, 20, 1, 1'b0, 1'b0);
    op_vec("ncall30", CALL, 1, 1'b0, 30, 1'b1, 20, 2, 1'b0, 1'b0);
    op_vec("nret31",  RET,  0, 1'b0, 0,  1'b1, 31, 3, 1'b0, 1'b0);
    op_vec("nret21",  RET,  0, 1'b0, 0,  1'b1, 21, 2, 1'b0, 1'b0);
    op_vec("nret11",  RET,  0, 1'b0, 0,  1'b1, 11, 1, 1'b0, 1'b0);
    op_vec("n_idle",  NOP,  0, 1'b0, 0,  1'b0, 0,  0, 1'b0, 1'b0);

    op_vec("fill1",   CALL, 1, 1'b0, 1,  1'b1, 20, 0, 1'b0, 1'b0);
    op_vec("fill2",   CALL, 1, 1'b0, 2,  1'b1, 20, 1, 1'b0, 1'b0);
    op_vec("fill3",   CALL, 1, 1'b0, 3,  1'b1, 20, 2, 1'b0, 1'b0);
    op_vec("fill63",  CALL, 1, 1'b0, 63, 1'b1, 20, 3, 1'b0, 1'b0);
    op_vec("call_ovf",CALL, 1, 1'b0, 5,  1'b0, 0,  4, 1'b0, 1'b0);
    op_vec("ovf_set", NOP,  0, 1'b0, 0,  1'b0, 0,  4, 1'b1, 1'b0);

    op_vec("dret0",   RET,  0, 1'b0, 0,  1'b1, 0,  4, 1'b1, 1'b0);
    op_vec("dret4",   RET,  0, 1'b0, 0,  1'b1, 4,  3, 1'b1, 1'b0);
    op_vec("dret3",   RET,  0, 1'b0, 0,  1'b1, 3,  2, 1'b1, 1'b0);
    op_vec("dret2",   RET,  0, 1'b0, 0,  1'b1, 2,  1, 1'b1, 1'b0);
    op_vec("ret_udf", RET,  0, 1'b0, 0,  1'b0, 0,  0, 1'b1, 1'b0);
    op_vec("udf_set", NOP,  0, 1'b0, 0,  1'b0, 0,  0, 1'b1, 1'b1);

    lut_write("wr_lut4_7", 4, 7, 0, 1'b1, 1'b1);
    apply_stimulus("wr_rd_same", 1'b1, 1'b1, JMP, 4, 1'b0, 0, 1'b1, 4, 9,
                   1'b1, 7, 0, 1'b1, 1'b1);
    op_vec("rd_new",  JMP,  4, 1'b0, 0,  1'b1, 9,  0, 1'b1, 1'b1);

    op_vec("pre_c1",  CALL, 1, 1'b0, 10, 1'b1, 20, 0, 1'b1, 1'b1);
    op_vec("pre_c2",  CALL, 1, 1'b0, 11, 1'b1, 20, 1, 1'b1, 1'b1);
    op_vec("depth2",  NOP,  0, 1'b0, 0,  1'b0, 0,  2, 1'b1, 1'b1);
    apply_stimulus("mid_reset", 1'b0, 1'b1, JMP, 4, 1'b0, 0, 1'b0, 0, 0,
                   1'b0, 0, 0, 1'b0, 1'b0);
    op_vec("post_rst4", JMP, 4, 1'b0, 0, 1'b1, 0, 0, 1'b0, 1'b0);
    op_vec("post_rst2", JMP, 2, 1'b0, 0, 1'b1, 0, 0, 1'b0, 1'b0);
    op_vec("post_ret",  RET, 0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);

    br_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
